// File: rtl/tx_frame_pkg.sv
// Shared definitions for the transmit frame controller: FSM state encoding,
// ALU function class decode and byte-count width helper.
package tx_frame_pkg;

   // FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_SEND      = 2'd1;
   localparam state_t ST_WAIT_ACK  = 2'd2;
   localparam state_t ST_WAIT_DONE = 2'd3;

   // ALU_FUN[3:2] value marking an arithmetic (full-width) result
   localparam logic [1:0] ALU_CLASS_ARITH = 2'b00;

   // Bits needed to hold a byte count in 0..alu_bytes
   function automatic int unsigned cnt_width(input int unsigned alu_bytes);
      return $clog2(alu_bytes + 1);
   endfunction

   function automatic logic is_arith(input logic [3:0] fun);
      return fun[3:2] == ALU_CLASS_ARITH;
   endfunction

endpackage

// File: rtl/tx_frame_if.sv
// Bus bundle between the register file / ALU / UART transmitter and the
// transmit frame controller.
//   master : drives RdData/Rd_valid, ALU_out/ALU_out_valid/ALU_FUN, Busy
//   slave  : drives Tx_Data/Tx_Data_valid, Fifo_full, Drop
interface tx_frame_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ALU_BYTES = 2
);
   logic [WIDTH-1:0]           RdData;
   logic                       Rd_valid;
   logic [ALU_BYTES*WIDTH-1:0] ALU_out;
   logic                       ALU_out_valid;
   logic [3:0]                 ALU_FUN;
   logic                       Busy;
   logic [WIDTH-1:0]           Tx_Data;
   logic                       Tx_Data_valid;
   logic                       Fifo_full;
   logic                       Drop;

   modport master (
      output RdData, Rd_valid, ALU_out, ALU_out_valid, ALU_FUN, Busy,
      input  Tx_Data, Tx_Data_valid, Fifo_full, Drop
   );

   modport slave (
      input  RdData, Rd_valid, ALU_out, ALU_out_valid, ALU_FUN, Busy,
      output Tx_Data, Tx_Data_valid, Fifo_full, Drop
   );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
//   clk, rst_n    : clock, async active-low reset
//   push, wdata   : write request (accepted if not full, or if popping too)
//   pop, rdata    : read request, head entry (valid while !empty)
//   full, empty   : registered occupancy flags
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wptr_q, rptr_q, wptr_d, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // A pop frees a slot in the same cycle, so push-while-full is legal then
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign wptr_d  = wptr_q + PW'(do_push);
   assign rptr_d  = rptr_q + PW'(do_pop);
   assign rdata   = mem_q[rptr_q[AW-1:0]];

   // Pointers and flags; flags computed from next pointers so they stay registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         full   <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
         empty  <= (wptr_d == rptr_d);
      end
   end

   // Storage array
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/tx_frame_ctrl.sv
// Transmit frame controller: queues register-read bytes and ALU results,
// then sends each request LSB byte first to the UART transmitter under the
// Busy handshake.
//   CLK, Reset : clock, async active-low reset
//   bus        : tx_frame_if slave (requests in, Tx byte stream and status out)
module tx_frame_ctrl
   import tx_frame_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned ALU_BYTES  = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic       CLK,
   input logic       Reset,
   tx_frame_if.slave bus
);
   localparam int unsigned PW = ALU_BYTES * WIDTH;
   localparam int unsigned CW = cnt_width(ALU_BYTES);
   localparam int unsigned EW = PW + CW;

   state_t          state_q, state_d;
   logic [PW-1:0]   shift_q, shift_d;
   logic [CW-1:0]   remain_q, remain_d;
   logic [WIDTH-1:0] tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            drop_q, drop_d;

   logic            push_req;
   logic [EW-1:0]   push_entry;
   logic            fifo_pop;
   logic [EW-1:0]   fifo_rdata;
   logic            fifo_full, fifo_empty;

   // Request classification; Rd wins when both strobes coincide
   always_comb begin
      push_req = bus.Rd_valid || bus.ALU_out_valid;
      if (bus.Rd_valid)
         push_entry = {CW'(1), PW'(bus.RdData)};
      else if (is_arith(bus.ALU_FUN))
         push_entry = {CW'(ALU_BYTES), bus.ALU_out};
      else
         push_entry = {CW'(1), bus.ALU_out};
   end

   // Discard on strobe collision, or on push into a full queue with no pop
   assign drop_d = (bus.Rd_valid && bus.ALU_out_valid) ||
                   (push_req && fifo_full && !fifo_pop);

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk   (CLK),
      .rst_n (Reset),
      .push  (push_req),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state and datapath decode
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      remain_d   = remain_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
      fifo_pop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !bus.Busy) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata[PW-1:0];
               remain_d = fifo_rdata[EW-1:PW];
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            tx_data_d  = shift_q[WIDTH-1:0];
            tx_valid_d = 1'b1;
            remain_d   = remain_q - CW'(1);
            shift_d    = shift_q >> WIDTH;
            state_d    = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (bus.Busy) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!bus.Busy) state_d = (remain_q != '0) ? ST_SEND : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Datapath and output registers
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         shift_q    <= '0;
         remain_q   <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         remain_q   <= remain_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         drop_q     <= drop_d;
      end
   end

   assign bus.Tx_Data       = tx_data_q;
   assign bus.Tx_Data_valid = tx_valid_q;
   assign bus.Fifo_full     = fifo_full;
   assign bus.Drop          = drop_q;
endmodule
